snn_feeder: RTL
===============

# snn_feeder

Host-side transmitter for the SNN accelerator input stream. Software or a preceding block loads 4 weight, 9 kernel and 72 image bytes (two 6x6 images, A then B) into local storage. On `start`, the feeder drives the SNN input protocol. It then waits for the single-cycle `out_valid` response, captures the 10-bit distance result and reports completion. It sits directly in front of the SNN core and is the only driver of its input bus.

## Interface
Parameters:
- `DATA_W`, default 8: width of the img/ker/weight bytes.
- `OUT_W`, default 10: width of the SNN result.
- `TIMEOUT_CYC`, default 1023: maximum number of WAIT cycles before abort (used only with the watchdog).

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load_valid`, in, 1: write strobe for local storage.
- `load_sel`, in, 2: target store; 0 = weight, 1 = kernel, 2 = image, 3 = ignored.
- `load_addr`, in, 7: byte index; weight 0–3, kernel 0–8, image 0–71 (0–35 = A, 36–71 = B, row-major).
- `load_data`, in, DATA_W: byte to write.
- `start`, in, 1: single-cycle request to begin a transfer.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, OUT_W: captured SNN output; held until the next accepted `start`.
- `timeout`, out, 1: sticky abort flag, cleared by an accepted `start`.
- `proto_err`, out, 1: sticky flag for `snn_out_valid` seen outside WAIT, cleared by an accepted `start`.
- `snn_in_valid`, out, 1: input-valid to the SNN core.
- `snn_img`, out, DATA_W: image byte to the SNN core.
- `snn_ker`, out, DATA_W: kernel byte to the SNN core.
- `snn_weight`, out, DATA_W: weight byte to the SNN core.
- `snn_out_valid`, in, 1: result-valid from the SNN core.
- `snn_out_data`, in, OUT_W: result from the SNN core.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - `start` -> SEND, and `cnt` is cleared to 0.
  - Loads are accepted only in IDLE. Loads in any other state, or with an out-of-range address, are dropped silently.
- SEND:
  - Lasts exactly 72 cycles, with `cnt` running 0..71. `snn_in_valid` is 1 throughout.
  - `snn_img` = img[cnt] on every cycle.
  - `snn_ker` = ker[cnt] while cnt < 9, else 0.
  - `snn_weight` = weight[cnt] while cnt < 4, else 0.
  - At cnt = 71 -> WAIT.
- WAIT:
  - `snn_in_valid` = 0 and all data outputs = 0.
  - On `snn_out_valid` = 1: `result` <= `snn_out_data`, -> DONE.
- DONE: `done` = 1 for one cycle, `busy` drops, -> IDLE.
- `start` in any state other than IDLE is ignored.
- `snn_out_valid` in IDLE, SEND or DONE sets `proto_err` and is otherwise ignored; `result` is unchanged.
- Storage holds its contents across transfers and is not cleared by `start`. Reset clears all storage to 0.
- A load and a `start` in the same IDLE cycle: the write takes effect, and the transfer sends the new value.

## Timing
- All outputs are registered.
- Reset values: `busy` 0, `done` 0, `result` 0, `timeout` 0, `proto_err` 0, `snn_in_valid` 0, `snn_img`/`snn_ker`/`snn_weight` 0. The FSM resets to IDLE.
- `start` sampled at cycle T: `snn_in_valid` is high for cycles T+1..T+72, and `busy` is high from T+1.
- `snn_out_valid` sampled at cycle R (in WAIT): `result` is valid and `done` = 1 at R+1, with `busy` = 0 in that same cycle. IDLE resumes at R+2.
- Minimum start-to-start spacing is 75 cycles, given the core's fixed latency.
- Reset asserted mid-SEND or mid-WAIT: on the next edge every output returns to its reset value and `snn_in_valid` drops immediately. A core response arriving later is then outside WAIT and is flagged via `proto_err`.

## Configuration
- `SNN_FEEDER_TIMEOUT_EN` defined:
  - An 11-bit watchdog counts WAIT cycles.
  - Once it exceeds `TIMEOUT_CYC` without `snn_out_valid`: `timeout` <= 1, `result` <= 0, -> DONE, so `done` still pulses.
- `SNN_FEEDER_TIMEOUT_EN` undefined:
  - No watchdog is built and WAIT waits indefinitely.
  - `timeout` is tied to 0.

## Structure
- Shared package `snn_pkg` holds:
  - WEIGHT_LEN = 4, KER_LEN = 9, IMG_LEN = 72.
  - The feeder state enum.
  - The `load_sel` encoding constants.
- Sub-module `snn_feeder_mem` holds the three register files. It has one write port and three combinational read ports (weight, kernel, image), all indexed by `cnt`.
- The top level holds the FSM, counters, watchdog and output registers.

## Test plan
- Load weight = {1,2,3,4}, kernel = all 1, image A = all 255, image B = all 0, then `start` -> exactly 72 `snn_in_valid` cycles. `snn_weight` sequence is 1,2,3,4,0..., `snn_ker` is 1 ×9 then 0, `snn_img` is 255 ×36 then 0 ×36.
- Model core returns `snn_out_valid` with data 10'd513 four cycles after SEND ends -> `result` = 513 and `done` pulses once, at R+1.
- `start` asserted again during SEND, and a load to image[5] = 0x77 during WAIT -> both ignored. The next transfer still sends the old image[5].
- Reset pulse at SEND cnt = 30 -> `snn_in_valid` = 0 on the next cycle and all outputs at reset values. A later `snn_out_valid` sets `proto_err` = 1.
- With `SNN_FEEDER_TIMEOUT_EN`, `TIMEOUT_CYC` = 20 and no core response -> `timeout` = 1, `result` = 0, `done` pulses. Both flags clear on the next `start`.
- Load with `load_sel` = 3, and a kernel load at address 12 -> storage unchanged, confirmed by readback through a SEND.

Source files
------------

// File: rtl/snn_feeder_pkg.sv
// Shared constants, load-select encoding and FSM state type for the SNN input feeder.
package snn_pkg;

    localparam int unsigned WEIGHT_LEN = 4;
    localparam int unsigned KER_LEN    = 9;
    localparam int unsigned IMG_LEN    = 72;
    localparam int unsigned CNT_W      = 7;

    localparam logic [1:0] SEL_WEIGHT = 2'd0;
    localparam logic [1:0] SEL_KER    = 2'd1;
    localparam logic [1:0] SEL_IMG    = 2'd2;
    localparam logic [1:0] SEL_NONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/snn_feeder_mem.sv
// Weight/kernel/image register files: one write port, three combinational read ports
// sharing a single index. Out-of-range reads return 0.
module snn_feeder_mem
    import snn_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [1:0]        sel_i,
    input  logic [CNT_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] weight_o,
    output logic [DATA_W-1:0] ker_o,
    output logic [DATA_W-1:0] img_o
);

    logic [DATA_W-1:0] weight_q [WEIGHT_LEN];
    logic [DATA_W-1:0] ker_q    [KER_LEN];
    logic [DATA_W-1:0] img_q    [IMG_LEN];

    logic weight_wr, ker_wr, img_wr;

    assign weight_wr = we_i && (sel_i == SEL_WEIGHT) && (addr_i < CNT_W'(WEIGHT_LEN));
    assign ker_wr    = we_i && (sel_i == SEL_KER)    && (addr_i < CNT_W'(KER_LEN));
    assign img_wr    = we_i && (sel_i == SEL_IMG)    && (addr_i < CNT_W'(IMG_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WEIGHT_LEN; i++) weight_q[i] <= '0;
            for (int unsigned i = 0; i < KER_LEN; i++)    ker_q[i]    <= '0;
            for (int unsigned i = 0; i < IMG_LEN; i++)    img_q[i]    <= '0;
        end else begin
            if (weight_wr) weight_q[addr_i[1:0]] <= wdata_i;
            if (ker_wr)    ker_q[addr_i[3:0]]    <= wdata_i;
            if (img_wr)    img_q[addr_i]         <= wdata_i;
        end
    end

    // A write in the same cycle as the read is forwarded, so a load issued
    // together with start is what the first SEND cycle transmits.
    always_comb begin
        weight_o = '0;
        ker_o    = '0;
        img_o    = '0;
        if (rd_idx_i < CNT_W'(WEIGHT_LEN)) begin
            weight_o = (weight_wr && addr_i == rd_idx_i) ? wdata_i : weight_q[rd_idx_i[1:0]];
        end
        if (rd_idx_i < CNT_W'(KER_LEN)) begin
            ker_o = (ker_wr && addr_i == rd_idx_i) ? wdata_i : ker_q[rd_idx_i[3:0]];
        end
        if (rd_idx_i < CNT_W'(IMG_LEN)) begin
            img_o = (img_wr && addr_i == rd_idx_i) ? wdata_i : img_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/snn_feeder.sv
// SNN input-stream feeder: local storage, IDLE/SEND/WAIT/DONE sequencer, registered outputs.
// Optional WAIT watchdog enabled by defining SNN_FEEDER_TIMEOUT_EN.
module snn_feeder
    import snn_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OUT_W       = 10,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [1:0]        load_sel,
    input  logic [6:0]        load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  result,
    output logic              timeout,
    output logic              proto_err,
    output logic              snn_in_valid,
    output logic [DATA_W-1:0] snn_img,
    output logic [DATA_W-1:0] snn_ker,
    output logic [DATA_W-1:0] snn_weight,
    input  logic              snn_out_valid,
    input  logic [OUT_W-1:0]  snn_out_data
);

    feeder_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept_start;
    logic              wd_expired;
    logic              send_d;

    logic [DATA_W-1:0] mem_weight, mem_ker, mem_img;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              proto_err_q, proto_err_d;
    logic              in_valid_q, in_valid_d;
    logic [DATA_W-1:0] img_q, img_d;
    logic [DATA_W-1:0] ker_q, ker_d;
    logic [DATA_W-1:0] weight_q, weight_d;

    assign accept_start = start && (state_q == ST_IDLE);

    // Read index is the next count so the output registers hold the byte for cnt.
    snn_feeder_mem #(
        .DATA_W(DATA_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we_i     (load_valid && (state_q == ST_IDLE)),
        .sel_i    (load_sel),
        .addr_i   (load_addr),
        .wdata_i  (load_data),
        .rd_idx_i (cnt_d),
        .weight_o (mem_weight),
        .ker_o    (mem_ker),
        .img_o    (mem_img)
    );

`ifdef SNN_FEEDER_TIMEOUT_EN
    logic [10:0] wd_q, wd_d;

    assign wd_expired = (state_q == ST_WAIT) && (wd_q >= 11'(TIMEOUT_CYC));
    assign wd_d       = (state_q == ST_WAIT) ? wd_q + 11'd1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (cnt_q == CNT_W'(IMG_LEN - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (snn_out_valid || wd_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        send_d      = (state_d == ST_SEND);
        in_valid_d  = send_d;
        img_d       = send_d ? mem_img    : '0;
        ker_d       = send_d ? mem_ker    : '0;
        weight_d    = send_d ? mem_weight : '0;
        busy_d      = (state_d == ST_SEND) || (state_d == ST_WAIT);
        done_d      = (state_d == ST_DONE);
        result_d    = result_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;

        if (accept_start) begin
            result_d    = '0;
            timeout_d   = 1'b0;
            proto_err_d = 1'b0;
        end

        if (state_q == ST_WAIT) begin
            if (snn_out_valid) begin
                result_d = snn_out_data;
            end else if (wd_expired) begin
                result_d  = '0;
                timeout_d = 1'b1;
            end
        end else if (snn_out_valid) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            in_valid_q  <= 1'b0;
            img_q       <= '0;
            ker_q       <= '0;
            weight_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            in_valid_q  <= in_valid_d;
            img_q       <= img_d;
            ker_q       <= ker_d;
            weight_q    <= weight_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign timeout      = timeout_q;
    assign proto_err    = proto_err_q;
    assign snn_in_valid = in_valid_q;
    assign snn_img      = img_q;
    assign snn_ker      = ker_q;
    assign snn_weight   = weight_q;

endmodule
